// File: rtl/sgd_x_writeback_engine.sv
// Copies the x vector from x memory to host memory as write lines.
// Two-word prefetch FIFO feeds a registered line output at one line/cycle.
module sgd_x_writeback_engine #(
   parameter int          RD_DATA_WIDTH = 2048,
   parameter int          LINE_WIDTH    = 512,
   parameter int          X_ADDR_WIDTH  = 10,
   parameter int          RD_LATENCY    = 2,
   parameter int          WORD_SHIFT    = 9,
   parameter logic [7:0]  TAG           = 8'h07
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [57:0]              base_addr,
   input  logic [31:0]              dimension,
   output logic                     busy,
   output logic                     done,
   output logic [X_ADDR_WIDTH-1:0]  x_mem_rd_addr,
   input  logic [RD_DATA_WIDTH-1:0] x_mem_rd_data,
   output logic [57:0]              um_tx_wr_addr,
   output logic [7:0]               um_tx_wr_tag,
   output logic                     um_tx_wr_valid,
   output logic [LINE_WIDTH-1:0]    um_tx_data,
   input  logic                     um_tx_wr_ready,
   output logic [31:0]              status
);

   localparam int LINES = RD_DATA_WIDTH / LINE_WIDTH;
   localparam int JW    = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CW    = 48;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   typedef logic [LINES-1:0][LINE_WIDTH-1:0] word_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [15:0]             acc_q, acc_d;
   logic [32:0]             nwords_q, nwords_d;
   logic [32:0]             next_w_q, next_w_d;
   logic [CW-1:0]           rem_q, rem_d;
   logic [RD_LATENCY:0]     pend_q, pend_d;
   logic [1:0]              cnt_q, cnt_d;
   word_t                   word0_q, word0_d;
   word_t                   word1_q, word1_d;
   logic [JW-1:0]           j_q, j_d;
   logic [X_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [57:0]             wr_addr_q, wr_addr_d;
   logic                    wr_valid_q, wr_valid_d;
   logic [LINE_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [7:0]              tag_q, tag_d;

   logic                    accept;
   logic                    last_slice;
   logic                    pop;
   logic                    cap;
   logic [3:0]              inflight;
   logic [3:0]              occ;
   logic [32:0]             nw;

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      err_d      = err_q;
      acc_d      = acc_q;
      nwords_d   = nwords_q;
      next_w_d   = next_w_q;
      rem_d      = rem_q;
      j_d        = j_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      tag_d      = TAG;

      accept     = wr_valid_q & um_tx_wr_ready;
      last_slice = (j_q == JW'(LINES - 1));
      pop        = accept & last_slice;
      cap        = pend_q[RD_LATENCY];

      inflight = 4'd0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
         inflight = inflight + 4'(pend_q[i]);
      end
      // occupancy after this edge: a pop frees its slot for a new read now
      occ = {2'b00, cnt_q} + inflight - {3'b000, pop};

      if (RD_LATENCY > 0) begin
         pend_d = {pend_q[RD_LATENCY-1:0], 1'b0};
      end else begin
         pend_d = '0;
      end

      word0_d = word0_q;
      word1_d = word1_q;
      cnt_d   = cnt_q;
      if (pop) begin
         word0_d = word1_q;
         cnt_d   = cnt_q - 2'd1;
      end
      if (cap) begin
         if (cnt_d == 2'd0) begin
            word0_d = x_mem_rd_data;
         end else begin
            word1_d = x_mem_rd_data;
         end
         cnt_d = cnt_d + 2'd1;
      end

      if (accept) begin
         j_d       = last_slice ? '0 : j_q + JW'(1);
         wr_addr_d = wr_addr_q + 58'd1;
         acc_d     = acc_q + 16'd1;
         rem_d     = rem_q - CW'(1);
      end

      nw = 33'(dimension[31:WORD_SHIFT])
         + 33'(|dimension[WORD_SHIFT-1:0]);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               nwords_d  = nw;
               rem_d     = CW'(nw) * CW'(LINES);
               acc_d     = 16'd0;
               wr_addr_d = base_addr;
               j_d       = '0;
               err_d     = (nw == 33'd0);
               if (nw == 33'd0) begin
                  state_d = FINISH;
               end else begin
                  state_d   = RUN;
                  rd_addr_d = '0;
                  pend_d[0] = 1'b1;
                  next_w_d  = 33'd1;
               end
            end
         end
         RUN: begin
            if ((next_w_q < nwords_q) && (occ < 4'd2)) begin
               rd_addr_d = next_w_q[X_ADDR_WIDTH-1:0];
               pend_d[0] = 1'b1;
               next_w_d  = next_w_q + 33'd1;
            end
            if (accept && (rem_q == CW'(1))) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end
         end
         FINISH: begin
            // empty runs arrive with done low and take one extra cycle
            if (done_q) begin
               state_d = IDLE;
            end else begin
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d == RUN);
      wr_valid_d = (state_d == RUN) && (cnt_d != 2'd0);
      wr_data_d  = word0_d[j_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         acc_q      <= '0;
         nwords_q   <= '0;
         next_w_q   <= '0;
         rem_q      <= '0;
         pend_q     <= '0;
         cnt_q      <= '0;
         word0_q    <= '0;
         word1_q    <= '0;
         j_q        <= '0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         acc_q      <= acc_d;
         nwords_q   <= nwords_d;
         next_w_q   <= next_w_d;
         rem_q      <= rem_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         word0_q    <= word0_d;
         word1_q    <= word1_d;
         j_q        <= j_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_valid_q <= wr_valid_d;
         wr_data_q  <= wr_data_d;
         tag_q      <= tag_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign x_mem_rd_addr  = rd_addr_q;
   assign um_tx_wr_addr  = wr_addr_q;
   assign um_tx_wr_tag   = tag_q;
   assign um_tx_wr_valid = wr_valid_q;
   assign um_tx_data     = wr_data_q;
   assign status         = {12'd0, acc_q, err_q, 1'b0, state_q};

endmodule

// File: tb/tb_sgd_x_writeback_engine.sv
// Directed bench for sgd_x_writeback_engine with a 2-cycle x-memory model.
module tb_sgd_x_writeback_engine;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [57:0]    base_addr = '0;
   logic [31:0]    dimension = '0;
   logic           busy, done;
   logic [9:0]     x_mem_rd_addr;
   logic [2047:0]  x_mem_rd_data;
   logic [57:0]    um_tx_wr_addr;
   logic [7:0]     um_tx_wr_tag;
   logic           um_tx_wr_valid;
   logic [511:0]   um_tx_data;
   logic           um_tx_wr_ready = 1'b1;
   logic [31:0]    status;

   int n_chk = 0;
   int n_fail = 0;

   sgd_x_writeback_engine dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .base_addr      (base_addr),
      .dimension      (dimension),
      .busy           (busy),
      .done           (done),
      .x_mem_rd_addr  (x_mem_rd_addr),
      .x_mem_rd_data  (x_mem_rd_data),
      .um_tx_wr_addr  (um_tx_wr_addr),
      .um_tx_wr_tag   (um_tx_wr_tag),
      .um_tx_wr_valid (um_tx_wr_valid),
      .um_tx_data     (um_tx_data),
      .um_tx_wr_ready (um_tx_wr_ready),
      .status         (status)
   );

   always #5 clk = ~clk;

   function automatic logic [2047:0] wordv(input int w);
      logic [2047:0] r;
      for (int i = 0; i < 64; i++) begin
         r[i*32 +: 32] = {8'(w + 1), 8'(i), 16'(w * 977 + i * 13)};
      end
      return r;
   endfunction

   logic [2047:0] s1_q, rd_q;
   always @(posedge clk) begin
      s1_q <= wordv(int'(x_mem_rd_addr));
      rd_q <= s1_q;
   end
   assign x_mem_rd_data = rd_q;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [57:0] base, input logic [31:0] dim,
                      input int stall_k, input int stall_len,
                      input bit mid_start);
      int n, t, k, st, first_v, nd, dc, ncyc;
      logic [57:0] h_a;
      logic [511:0] h_d, exp_d;
      logic [2047:0] wv;
      n = int'(dim / 512) + ((dim % 512) != 0 ? 1 : 0);
      t = n * 4;
      k = 0; st = 0; first_v = -1; nd = 0; dc = -1;
      ncyc = 8 + t + stall_len;
      @(negedge clk);
      base_addr = base;
      dimension = dim;
      start = 1'b1;
      um_tx_wr_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_c1", busy, n > 0);
      if (n > 0) chk("rd_addr_c1", x_mem_rd_addr, 0);
      for (int c = 1; c <= ncyc; c++) begin
         if (mid_start && c == 5) begin
            start = 1'b1;
            base_addr = 58'h0;
            dimension = 32'd0;
         end else begin
            start = 1'b0;
         end
         if (stall_k >= 0 && um_tx_wr_valid && k == stall_k && st < stall_len) begin
            if (st == 0) begin
               h_a = um_tx_wr_addr;
               h_d = um_tx_data;
            end else begin
               chk("hold_addr", um_tx_wr_addr, h_a);
               chk("hold_data", um_tx_data, h_d);
            end
            um_tx_wr_ready = 1'b0;
            st++;
         end else begin
            um_tx_wr_ready = 1'b1;
         end
         if (um_tx_wr_valid && first_v < 0) first_v = c;
         if (um_tx_wr_valid && um_tx_wr_ready) begin
            wv = wordv(k / 4);
            exp_d = wv[(k % 4)*512 +: 512];
            chk("wr_addr", um_tx_wr_addr, 58'(base + 58'(k)));
            chk("wr_tag", um_tx_wr_tag, 8'h07);
            chk("wr_data", um_tx_data, exp_d);
            k++;
         end
         if (done) begin
            nd++;
            dc = c;
            chk("busy_at_done", busy, 0);
         end
         @(posedge clk);
         #1;
      end
      um_tx_wr_ready = 1'b1;
      chk("lines", k, t);
      chk("done_count", nd, 1);
      chk("done_cycle", dc, (n == 0) ? 2 : 4 + t + stall_len);
      if (n > 0) chk("first_valid", first_v, 4);
      else       chk("no_valid", first_v < 0, 1);
      chk("stat_lines", status[19:4], 16'(t));
      chk("stat_err", status[3], n == 0);
      chk("stat_idle", status[2:0], 0);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_valid"}, um_tx_wr_valid, 0);
      chk({pfx, "_addr"}, um_tx_wr_addr, 0);
      chk({pfx, "_tag"}, um_tx_wr_tag, 0);
      chk({pfx, "_data"}, um_tx_data, 0);
      chk({pfx, "_rdaddr"}, x_mem_rd_addr, 0);
      chk({pfx, "_status"}, status, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run(58'h100, 32'd1024, -1, 0, 1'b0);
      run(58'h2000, 32'd513, -1, 0, 1'b0);
      run(58'h40, 32'd512, -1, 0, 1'b0);
      run(58'h300, 32'd1024, 2, 10, 1'b0);
      run(58'h80, 32'd0, -1, 0, 1'b0);
      run(58'h10, 32'd512, -1, 0, 1'b0);
      run(58'h3FF_FFFF_FFFF_FFFE, 32'd512, -1, 0, 1'b1);

      @(negedge clk);
      base_addr = 58'h777;
      dimension = 32'd2048;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("mid_valid_before", um_tx_wr_valid, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run(58'h500, 32'd1024, -1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
